spi_flash_responder: RTL

- Synthesizable SPI mode-0 responder that emulates the read subset of a W25Q32-class serial flash.
- Lets the SPI loader master be exercised on hardware against an on-chip byte store (BRAM/ROM) instead of a physical flash part.
- All logic runs on MCLK. The SPI pins are oversampled; SPI CLK frequency must be ≤ MCLK/8.
- Answers READ DATA (0x03), JEDEC ID (0x9F) and READ STATUS-1 (0x05). Every other opcode is ignored.

---
 rtl/spi_flash_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating the read subset of a W25Q32-class flash
// (READ DATA 0x03, JEDEC ID 0x9F, READ STATUS-1 0x05) over an on-chip byte store.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 22,
  parameter logic [7:0]  JEDEC_MFR  = 8'hEF,
  parameter logic [7:0]  JEDEC_TYPE = 8'h40,
  parameter logic [7:0]  JEDEC_CAP  = 8'h16,
  parameter logic [7:0]  STATUS1    = 8'h00
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  input  logic                  nCS,
  input  logic                  CLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic [ADDR_WIDTH-1:0] MEMADDR,
  output logic                  MEMRD,
  input  logic [7:0]            MEMDATA,
  output logic                  BUSY
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

  state_t                state_r, state_n;
  logic                  ncs_meta_r, ncs_sync_r;
  logic                  sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic                  mosi_meta_r, mosi_sync_r;
  logic                  armed_r;
  logic [2:0]            bit_cnt_r;
  logic [4:0]            addr_cnt_r;
  logic [7:0]            rx_r, tx_r, pf_r;
  logic [ADDR_WIDTH-1:0] addr_sh_r;
  logic [1:0]            id_idx_r;
  logic                  memrd_d_r;
  logic                  rise_s, fall_s;
  logic [7:0]            rx_next_s, byte_src_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;

  assign rise_s      = sclk_sync_r & ~sclk_prev_r;
  assign fall_s      = ~sclk_sync_r & sclk_prev_r;
  assign rx_next_s   = {rx_r[6:0], mosi_sync_r};
  assign addr_next_s = {addr_sh_r[ADDR_WIDTH-2:0], mosi_sync_r};

  // Next-state decode and selection of the byte that starts each output byte
  always_comb begin
    state_n    = state_r;
    byte_src_s = 8'h00;
    if (ncs_sync_r) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (armed_r) state_n = CMD;
          else         state_n = IDLE;
        end
        CMD: begin
          if (rise_s && bit_cnt_r == 3'd7) begin
            case (rx_next_s)
              8'h03:   state_n = ADDR;
              8'h9F:   state_n = ID;
              8'h05:   state_n = STAT;
              default: state_n = IGNORE;
            endcase
          end else begin
            state_n = CMD;
          end
        end
        ADDR: begin
          if (rise_s && addr_cnt_r == 5'd23) state_n = DATA;
          else                               state_n = ADDR;
        end
        default: state_n = state_r;
      endcase
    end
    case (state_r)
      DATA: byte_src_s = pf_r;
      ID: begin
        case (id_idx_r)
          2'd0:    byte_src_s = JEDEC_MFR;
          2'd1:    byte_src_s = JEDEC_TYPE;
          default: byte_src_s = JEDEC_CAP;
        endcase
      end
      STAT:    byte_src_s = STATUS1;
      default: byte_src_s = 8'h00;
    endcase
  end

  // State register, synchronizers, shifters and registered outputs
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_r     <= IDLE;
      ncs_meta_r  <= 1'b0;
      ncs_sync_r  <= 1'b0;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      armed_r     <= 1'b0;
      bit_cnt_r   <= 3'd0;
      addr_cnt_r  <= 5'd0;
      rx_r        <= 8'h00;
      tx_r        <= 8'h00;
      pf_r        <= 8'h00;
      addr_sh_r   <= {ADDR_WIDTH{1'b0}};
      id_idx_r    <= 2'd0;
      memrd_d_r   <= 1'b0;
      MISO        <= 1'b0;
      MISO_OE     <= 1'b0;
      MEMADDR     <= {ADDR_WIDTH{1'b0}};
      MEMRD       <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      ncs_meta_r  <= nCS;
      ncs_sync_r  <= ncs_meta_r;
      sclk_meta_r <= CLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      mosi_meta_r <= MOSI;
      mosi_sync_r <= mosi_meta_r;
      state_r     <= state_n;
      BUSY        <= (state_n != IDLE);
      memrd_d_r   <= MEMRD;
      MEMRD       <= 1'b0;
      // After reset a transaction may only start once nCS has been seen high
      if (ncs_sync_r) armed_r <= 1'b1;
      else            armed_r <= armed_r;
      if (memrd_d_r) pf_r <= MEMDATA;
      else           pf_r <= pf_r;
      if (ncs_sync_r) begin
        MISO      <= 1'b0;
        MISO_OE   <= 1'b0;
        bit_cnt_r <= 3'd0;
      end else begin
        case (state_r)
          IDLE: begin
            bit_cnt_r  <= 3'd0;
            addr_cnt_r <= 5'd0;
            rx_r       <= 8'h00;
            addr_sh_r  <= {ADDR_WIDTH{1'b0}};
            id_idx_r   <= 2'd0;
            MISO_OE    <= 1'b0;
          end
          CMD: begin
            if (rise_s) begin
              rx_r      <= rx_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
              rx_r <= rx_r;
            end
          end
          ADDR: begin
            if (rise_s) begin
              addr_sh_r  <= addr_next_s;
              addr_cnt_r <= addr_cnt_r + 5'd1;
              if (addr_cnt_r == 5'd23) begin
                MEMADDR <= addr_next_s;
                MEMRD   <= 1'b1;
              end else begin
                MEMRD <= 1'b0;
              end
            end else begin
              addr_sh_r <= addr_sh_r;
            end
          end
          DATA, ID, STAT: begin
            if (fall_s) begin
              MISO_OE   <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd0) begin
                MISO <= byte_src_s[7];
                tx_r <= {byte_src_s[6:0], 1'b0};
                if (state_r == ID) id_idx_r <= (id_idx_r == 2'd2) ? 2'd0 : id_idx_r + 2'd1;
                else               id_idx_r <= id_idx_r;
              end else begin
                MISO <= tx_r[7];
                tx_r <= {tx_r[6:0], 1'b0};
              end
              // Prefetch the next byte once the current one has fully shifted out
              if (state_r == DATA && bit_cnt_r == 3'd7) begin
                MEMADDR <= MEMADDR + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                MEMRD   <= 1'b1;
              end else begin
                MEMRD <= 1'b0;
              end
            end else begin
              tx_r <= tx_r;
            end
          end
          default: MISO_OE <= 1'b0;
        endcase
      end
    end
  end

endmodule
